// File: rtl/mips_mem_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// Holds the arbiter state encoding and the timeout fill word.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic [31:0] TIMEOUT_FILL = 32'h0;

endpackage

// File: rtl/mem_arb_timer.sv
// Ack-wait counter: counts access cycles without mem_ack and
// flags the cycle in which the count reaches ACK_TIMEOUT.
module mem_arb_timer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The increment that lands on ACK_TIMEOUT is the expiring one.
    assign expired = en && (r_cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port unified memory,
// with starvation guard for fetch and a sticky ack-timeout flag.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int STARVE_MAX  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    arb_state_t  r_state;
    logic [SW-1:0] r_starve;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;
    logic        r_if_ready;
    logic        r_dm_ready;
    logic        r_err;

    logic        w_access;
    logic        w_pick_dm;
    logic        w_tmr_clr;
    logic        w_tmr_en;
    logic        w_expired;
    logic [31:0] w_fill;
    logic [SW-1:0] w_starve_inc;

    assign w_access  = (r_state == IF_ACC) || (r_state == DM_ACC);
    assign w_pick_dm = dm_req && (!if_req || (r_starve < STARVE_TOP));
    assign w_tmr_clr = (r_state == IDLE);
    assign w_tmr_en  = w_access && !mem_ack;
    assign w_fill    = mem_ack ? mem_rdata : TIMEOUT_FILL;
    assign w_starve_inc = (r_starve == STARVE_TOP) ? r_starve
                                                   : r_starve + 1'b1;

    mem_arb_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_tmr_clr),
        .en     (w_tmr_en),
        .expired(w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_starve    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_pick_dm) begin
                        r_state     <= DM_ACC;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                        r_starve    <= if_req ? w_starve_inc : '0;
                    end else if (if_req) begin
                        r_state     <= IF_ACC;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_starve    <= '0;
                    end
                end
                IF_ACC, DM_ACC: begin
                    if (mem_ack || w_expired) begin
                        r_state   <= DONE;
                        r_mem_req <= 1'b0;
                        if (w_expired) begin
                            r_err <= 1'b1;
                        end
                        if (r_state == DM_ACC) begin
                            r_dm_ready <= 1'b1;
                            // Acked writes keep the last read word.
                            if (!mem_ack || !r_mem_we) begin
                                r_dm_rdata <= w_fill;
                            end
                        end else begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= w_fill;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;
    assign busy      = (r_state != IDLE);
    assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;

    localparam int STARVE_MAX  = 4;
    localparam int ACK_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level reference state
    int          m_starve = 0;
    logic [31:0] m_if_rd = '0;
    logic [31:0] m_dm_rd = '0;
    logic        m_err = 1'b0;

    logic won;

    mem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serve one grant: ack arrives in access cycle 'lat' (never if
    // lat > ACK_TIMEOUT). Entered at a negedge with requests set up.
    task automatic grant(input int lat, input logic [31:0] rd,
                         input int exp_wait, output logic won_dm);
        logic [31:0] ea;
        logic [31:0] ewd;
        logic        ewe;
        logic        acked;
        logic        tmo;
        int          n;
        int          c;

        won_dm = dm_req && (!if_req || m_starve < STARVE_MAX);
        ea  = won_dm ? dm_addr : if_addr;
        ewe = won_dm ? dm_we : 1'b0;
        ewd = dm_wdata;
        if (won_dm && if_req) begin
            if (m_starve < STARVE_MAX) m_starve++;
        end else begin
            m_starve = 0;
        end

        n = 0;
        while (!mem_req && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("grant_wait", n, exp_wait);
        chk("mem_req_on", mem_req, 1);
        chk("mem_addr", mem_addr, ea);
        chk("mem_we", mem_we, ewe);
        if (won_dm) chk("mem_wdata", mem_wdata, ewd);
        chk("busy_acc", busy, 1);

        c = 1;
        acked = 1'b0;
        forever begin
            if (c == lat) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
                acked = 1'b1;
            end else begin
                mem_rdata = $urandom;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            if (acked || c == ACK_TIMEOUT) break;
            if (!mem_req) break;
            c++;
        end
        tmo = !acked;
        chk("req_cycles", c, tmo ? ACK_TIMEOUT : lat);

        if (tmo) m_err = 1'b1;
        if (won_dm) begin
            if (tmo) m_dm_rd = 32'h0;
            else if (!ewe) m_dm_rd = rd;
        end else begin
            m_if_rd = tmo ? 32'h0 : rd;
        end

        chk("if_ready_done", if_ready, !won_dm);
        chk("dm_ready_done", dm_ready, won_dm);
        chk("if_rdata_done", if_rdata, m_if_rd);
        chk("dm_rdata_done", dm_rdata, m_dm_rd);
        chk("mem_req_done", mem_req, 0);
        chk("addr_stable", mem_addr, ea);
        chk("err_done", err, m_err);

        // Ack during DONE must be ignored
        mem_ack = 1'b1;
        mem_rdata = ~rd;
        if (won_dm) dm_req = 1'b0;
        else if_req = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("if_ready_after", if_ready, 0);
        chk("dm_ready_after", dm_ready, 0);
        chk("if_rdata_after", if_rdata, m_if_rd);
        chk("dm_rdata_after", dm_rdata, m_dm_rd);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_dm_ready", dm_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Fetch only
        if_addr = 32'h40;
        if_req = 1'b1;
        grant(1, 32'h2002_0005, 1, won);
        chk("f_rdata", if_rdata, 32'h2002_0005);
        chk("f_addr", mem_addr, 32'h40);

        // Simultaneous: data write first, then fetch
        dm_we = 1'b1;
        dm_addr = 32'h54;
        dm_wdata = 32'd7;
        dm_req = 1'b1;
        if_addr = 32'h80;
        if_req = 1'b1;
        grant(2, 32'h1234_5678, 1, won);
        chk("s_addr", mem_addr, 32'h54);
        chk("s_we", mem_we, 1);
        chk("s_wdata", mem_wdata, 32'd7);
        chk("s_dm_rdata", dm_rdata, 32'h0);
        grant(1, 32'h0BAD_F00D, 1, won);
        chk("s_f_addr", mem_addr, 32'h80);
        chk("s_f_rdata", if_rdata, 32'h0BAD_F00D);

        // Starvation: four data grants, then fetch
        dm_we = 1'b0;
        if_addr = 32'h2000;
        if_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dm_addr = 32'h1000 + 32'(4 * i);
            dm_req = 1'b1;
            grant(2, $urandom, 1, won);
            chk("starve_addr", mem_addr,
                (i < 4) ? 32'h1000 + 32'(4 * i) : 32'h2000);
        end
        if_addr = 32'h2004;
        if_req = 1'b1;
        grant(1, $urandom, 1, won);
        chk("starve_clr", mem_addr, 32'h1010);
        grant(1, $urandom, 1, won);
        chk("starve_f2", mem_addr, 32'h2004);

        // Timeout on a data read, then a normal fetch
        dm_we = 1'b0;
        dm_addr = 32'h300;
        dm_req = 1'b1;
        grant(ACK_TIMEOUT + 12, 32'hFFFF_FFFF, 1, won);
        chk("to_rdata", dm_rdata, 32'h0);
        chk("to_err", err, 1);
        if_addr = 32'h400;
        if_req = 1'b1;
        grant(3, 32'hCAFE_0001, 1, won);
        chk("to_after", if_rdata, 32'hCAFE_0001);
        chk("to_err_held", err, 1);

        // Stray acks while idle
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_req", mem_req, 0);
        chk("stray_busy", busy, 0);
        chk("stray_ifr", if_ready, 0);
        chk("stray_dmr", dm_ready, 0);
        chk("stray_ifd", if_rdata, m_if_rd);
        chk("stray_dmd", dm_rdata, m_dm_rd);

        // Ack-latency sweep on both ports
        for (int lat = 1; lat <= 20; lat++) begin
            if_addr = $urandom;
            if_req = 1'b1;
            grant(lat, $urandom, 1, won);
            dm_we = 1'b0;
            dm_addr = $urandom;
            dm_req = 1'b1;
            grant(lat, $urandom, 1, won);
        end

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req = 1'b1;
                if_addr = $urandom;
            end
            if (!dm_req && $urandom_range(0, 1) == 1) begin
                dm_req = 1'b1;
                dm_we = 1'($urandom_range(0, 1));
                dm_addr = $urandom;
                dm_wdata = $urandom;
            end
            if (!if_req && !dm_req) begin
                if_req = 1'b1;
                if_addr = $urandom;
            end
            grant(int'($urandom_range(1, 10)), $urandom, 1, won);
        end
        for (int i = 0; i < 2; i++) begin
            if (if_req || dm_req) grant(1, $urandom, 1, won);
        end

        // Reset in the middle of an access
        if_addr = 32'h500;
        if_req = 1'b1;
        @(negedge clk);
        chk("mid_req", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_mem_req", mem_req, 0);
        chk("mid_busy", busy, 0);
        chk("mid_addr", mem_addr, 0);
        chk("mid_we", mem_we, 0);
        chk("mid_wdata", mem_wdata, 0);
        chk("mid_err", err, 0);
        chk("mid_ifd", if_rdata, 0);
        chk("mid_dmd", dm_rdata, 0);
        m_starve = 0;
        m_err = 1'b0;
        m_if_rd = '0;
        m_dm_rd = '0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("mid_ifr", if_ready, 0);
        chk("mid_dmr", dm_ready, 0);
        if_addr = 32'h600;
        reset = 1'b1;
        @(negedge clk);
        chk("rel_grant", mem_req, 1);
        grant(2, 32'h600D_0600, 0, won);
        chk("rel_rdata", if_rdata, 32'h600D_0600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, 4, consecutive data grants allowed while fetch waits.
REQ-002 SHALL have parameter ACK_TIMEOUT, 255, max cycles in an access state without mem_ack.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports if_req in 1 fetch request; if_addr in 32 fetch address; if_rdata out 32 fetched word; if_ready out 1 fetch done pulse.
REQ-006 SHALL have ports dm_req in 1; dm_we in 1; dm_addr in 32; dm_wdata in 32; dm_rdata out 32; dm_ready out 1 data done pulse.
REQ-007 SHALL have ports mem_req out 1; mem_we out 1; mem_addr out 32; mem_wdata out 32; mem_rdata in 32; mem_ack in 1 (single-port unified memory).
REQ-008 SHALL have ports busy out 1 (state != IDLE) and err out 1 (sticky timeout flag).

Function
REQ-009 SHALL implement FSM states IDLE, IF_ACC, DM_ACC, DONE.
REQ-010 IDLE: dm_req=1 and (if_req=0 or starve_cnt<STARVE_MAX) SHALL go to DM_ACC; else if_req=1 SHALL go to IF_ACC; else stay.
REQ-011 On grant SHALL latch the winner's addr, we (0 for fetch), wdata into mem_addr/mem_we/mem_wdata registers; outputs SHALL stay stable until DONE.
REQ-012 mem_req SHALL be 1 exactly in IF_ACC and DM_ACC.
REQ-013 In an access state, mem_ack=1 SHALL capture mem_rdata into the granted port's rdata register and go to DONE.
REQ-014 DONE SHALL assert the granted port's ready for exactly one cycle, then go to IDLE; the other port's ready SHALL stay 0.
REQ-015 Minimum latency: req sampled in IDLE at cycle N, mem_ack at N+1 -> ready at N+2.
REQ-016 rdata SHALL hold its last captured value until the next completion on that port; dm write completions SHALL leave dm_rdata unchanged.
REQ-017 Requesters SHALL hold req/addr/wdata until ready; req sampled in IDLE after DONE SHALL be treated as a new request.
REQ-018 starve_cnt (width $clog2(STARVE_MAX+1)) SHALL increment, saturating, on each DM grant with if_req=1, and clear on each IF grant or DM grant with if_req=0.
REQ-019 Simultaneous if_req and dm_req with starve_cnt=STARVE_MAX SHALL grant fetch.
REQ-020 Wait counter SHALL clear on grant, increment each access-state cycle without mem_ack; on reaching ACK_TIMEOUT SHALL go to DONE, drop mem_req, load 32'h0 into the granted rdata, set err.
REQ-021 err SHALL stay 1 until reset; arbitration SHALL continue normally after a timeout.
REQ-022 mem_ack in IDLE or DONE SHALL be ignored.

Reset
REQ-023 reset=0 SHALL asynchronously force state IDLE, starve_cnt 0, wait counter 0, err 0, mem_req 0, mem_we 0, mem_addr/mem_wdata 0, if_rdata/dm_rdata 0, if_ready/dm_ready 0, busy 0.
REQ-024 Reset mid-access SHALL abandon the transaction with no ready pulse; first grant possible on the first rising edge after reset release.

Structure
REQ-025 The state enum and the timeout fill value 32'h0 SHALL live in shared package mips_mem_pkg.
REQ-026 The ack-wait counter with timeout compare SHALL be sub-module mem_arb_timer (inputs clk, reset, clr, en; output expired).

Verification
REQ-027 Fetch only: if_req=1, if_addr=0x40, mem_ack one cycle after mem_req, mem_rdata=0x20020005 -> mem_we=0, mem_addr=0x40, if_rdata=0x20020005, if_ready one cycle, dm_ready=0.
REQ-028 Simultaneous: both req at cycle 0, dm_we=1, dm_addr=0x54, dm_wdata=7 -> data first (mem_we=1, mem_addr=0x54, mem_wdata=7), dm_ready pulse, then fetch serviced.
REQ-029 Starvation: dm_req and if_req held high, STARVE_MAX=4 -> 4 data grants, 5th grant to fetch, starve_cnt back to 0.
REQ-030 Timeout: ACK_TIMEOUT=8, mem_ack never asserted -> mem_req high 8 cycles, dm_ready pulse with dm_rdata=0, err=1 held; next request completes normally with err still 1.
REQ-031 Reset mid-access: reset=0 while mem_req=1 -> mem_req=0 immediately, no ready pulse, all outputs at reset values.
REQ-032 Ack-latency sweep 1..20 cycles on both ports -> ready exactly one cycle after mem_ack, one pulse per request, rdata matches mem_rdata.
